// File: rtl/mult_pkg.sv
// Shared constants and Booth step decoding for the registered sequential multiplier.
package mult_pkg;

    localparam int MULT_WIDTH        = 32;
    localparam int MULT_FRAME_CYCLES = 64;
    localparam int MULT_CNT_W        = $clog2(MULT_FRAME_CYCLES);

    typedef enum logic [1:0] {
        BOOTH_NOP = 2'b00,
        BOOTH_ADD = 2'b01,
        BOOTH_SUB = 2'b10
    } booth_op_e;

    // Radix-2 Booth recoding of the pair {q0, q-1}.
    function automatic booth_op_e booth_decode(input logic q0, input logic qm1);
        booth_op_e op;
        case ({q0, qm1})
            2'b01:   op = BOOTH_ADD;
            2'b10:   op = BOOTH_SUB;
            default: op = BOOTH_NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/booth_seq_engine.sv
// Sequential radix-2 Booth engine: one add/sub-and-shift step per enabled clock,
// WIDTH steps per product; result held until the next start.
module booth_seq_engine
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product,
    output logic               done
);

    localparam int STEP_W = $clog2(WIDTH + 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(WIDTH);

    logic [WIDTH:0]    acc_q, acc_d;
    logic [WIDTH-1:0]  mq_q, mq_d;
    logic              qm1_q, qm1_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [WIDTH:0]    m_s;
    logic [WIDTH:0]    sum_s;
    logic              done_s;
    booth_op_e         op_s;

    // Booth add/subtract of the sign-extended multiplicand; one extra accumulator
    // bit keeps (-2^(W-1)) * (-2^(W-1)) exact.
    always_comb begin
        m_s    = {a[WIDTH-1], a};
        op_s   = booth_decode(mq_q[0], qm1_q);
        done_s = (step_q == STEP_LAST);
        case (op_s)
            BOOTH_ADD: sum_s = acc_q + m_s;
            BOOTH_SUB: sum_s = acc_q - m_s;
            default:   sum_s = acc_q;
        endcase
    end

    // Next state: load on start, otherwise arithmetic-shift {A,Q,q-1} until done.
    always_comb begin
        acc_d  = acc_q;
        mq_d   = mq_q;
        qm1_d  = qm1_q;
        step_d = step_q;
        if (enable && start) begin
            acc_d  = {(WIDTH + 1){1'b0}};
            mq_d   = b;
            qm1_d  = 1'b0;
            step_d = {STEP_W{1'b0}};
        end else if (enable && !done_s) begin
            acc_d  = {sum_s[WIDTH], sum_s[WIDTH:1]};
            mq_d   = {sum_s[0], mq_q[WIDTH-1:1]};
            qm1_d  = mq_q[0];
            step_d = step_q + STEP_W'(1);
        end else begin
            acc_d  = acc_q;
        end
    end

    // Engine state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q  <= {(WIDTH + 1){1'b0}};
            mq_q   <= {WIDTH{1'b0}};
            qm1_q  <= 1'b0;
            step_q <= {STEP_W{1'b0}};
        end else begin
            acc_q  <= acc_d;
            mq_q   <= mq_d;
            qm1_q  <= qm1_d;
            step_q <= step_d;
        end
    end

    assign product = {acc_q[WIDTH-1:0], mq_q};
    assign done    = done_s;

endmodule

// File: rtl/registered_seq_mult.sv
// Frame-based registered signed multiplier: operands sampled and product registered
// at each frame boundary. Define OUT_VALID_EN to add the out_valid pulse output.
module registered_seq_mult
    import mult_pkg::*;
#(
    parameter int WIDTH        = MULT_WIDTH,
    parameter int FRAME_CYCLES = MULT_FRAME_CYCLES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [WIDTH-1:0]   in1,
    input  logic [WIDTH-1:0]   in2,
    output logic [2*WIDTH-1:0] out
`ifdef OUT_VALID_EN
    ,
    output logic               out_valid
`endif
);

    localparam int CNT_W = $clog2(FRAME_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYCLES - 1);

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               start_q, start_d;
    logic [2*WIDTH-1:0] out_q, out_d;
    logic               boundary_s;
    logic [2*WIDTH-1:0] eng_product_s;
    logic               eng_done_s;

    // Frame counter, operand capture and product capture at the boundary. The engine
    // is started on the next enabled clock so it reads the freshly captured operands.
    always_comb begin
        boundary_s = enable && (cnt_q == CNT_LAST);
        cnt_d      = cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        out_d      = out_q;
        start_d    = enable ? boundary_s : start_q;
        if (boundary_s) begin
            cnt_d = {CNT_W{1'b0}};
            a_d   = in1;
            b_d   = in2;
            out_d = eng_done_s ? eng_product_s : {(2 * WIDTH){1'b0}};
        end else if (enable) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Frame, operand and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= {CNT_W{1'b0}};
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            start_q <= 1'b0;
            out_q   <= {(2 * WIDTH){1'b0}};
        end else begin
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            start_q <= start_d;
            out_q   <= out_d;
        end
    end

    booth_seq_engine #(
        .WIDTH (WIDTH)
    ) u_engine (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .start   (start_q),
        .a       (a_q),
        .b       (b_q),
        .product (eng_product_s),
        .done    (eng_done_s)
    );

    assign out = out_q;

`ifdef OUT_VALID_EN
    logic out_valid_q, out_valid_d;

    // One-clock pulse alongside each product that came from a completed engine run.
    always_comb begin
        out_valid_d = boundary_s && eng_done_s;
    end

    // Valid pulse register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
`endif

endmodule

// File: tb/tb_registered_seq_mult.sv
// Randomized self-checking bench for registered_seq_mult against a frame-level model.
module tb_registered_seq_mult;

    localparam int FRAME = 64;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [63:0] out;

    int n_checks = 0;
    int n_fail   = 0;

    // Frame-level reference: count enabled clocks, swap pending product at boundaries.
    int          m_cnt;
    logic [63:0] m_pend;
    logic [63:0] exp_out;

    registered_seq_mult dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .in1    (in1),
        .in2    (in2),
        .out    (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", tag,
                     $signed(got), got, $signed(exp), exp);
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cnt   <= 0;
            m_pend  <= 64'd0;
            exp_out <= 64'd0;
        end else if (enable) begin
            if (m_cnt == FRAME - 1) begin
                m_cnt   <= 0;
                exp_out <= m_pend;
                m_pend  <= longint'($signed(in1)) * longint'($signed(in2));
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    always @(negedge clk) begin
        check_val("out_vs_model", out, exp_out);
    end

    // One frame with operands a,b; a glitch mid-frame must be ignored.
    task automatic run_frame(input logic [31:0] a, input logic [31:0] b);
        in1 = a;
        in2 = b;
        repeat (30) @(negedge clk);
        in1 = $urandom;
        in2 = $urandom;
        repeat (20) @(negedge clk);
        in1 = a;
        in2 = b;
        repeat (FRAME - 50) @(negedge clk);
    endtask

    task automatic run_stall_frame(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] held;
        in1 = a;
        in2 = b;
        repeat (20) @(negedge clk);
        enable = 1'b0;
        held   = out;
        in1    = $urandom;
        in2    = $urandom;
        repeat (100) @(negedge clk);
        check_val("stall_hold", out, held);
        in1    = a;
        in2    = b;
        enable = 1'b1;
        repeat (FRAME - 20) @(negedge clk);
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b1;
        in1    = 32'd0;
        in2    = 32'd0;
        repeat (3) @(negedge clk);
        check_val("reset_out", out, 64'd0);
        reset = 1'b0;

        run_frame(-32'sd5, 32'sd5);
        check_val("first_boundary_zero", out, 64'd0);
        run_frame(32'sd4, 32'sd10);
        check_val("tp_m25", out, -64'sd25);
        run_frame(-32'sd4, -32'sd10);
        check_val("tp_40", out, 64'sd40);
        run_frame(32'sd0, 32'sd3);
        check_val("tp_40b", out, 64'sd40);
        run_frame(32'sd1, 32'sd3);
        check_val("tp_0", out, 64'sd0);
        run_frame(32'sd3, 32'sd7);
        check_val("tp_3", out, 64'sd3);
        run_frame(32'sd2, -32'sd2);
        check_val("tp_21", out, 64'sd21);
        run_frame(32'sd5, 32'sd7);
        check_val("tp_m4", out, -64'sd4);
        run_frame(32'sd0, 32'sd0);
        check_val("tp_35", out, 64'sd35);

        run_frame(32'sd300, 32'sd3);
        run_frame(32'sd300, 32'sd3);
        check_val("hold_900", out, 64'sd900);

        run_frame(32'h8000_0000, 32'h8000_0000);
        run_frame(32'h7FFF_FFFF, 32'hFFFF_FFFF);
        check_val("corner_min_sq", out, 64'h4000_0000_0000_0000);
        run_frame(32'h8000_0000, 32'h7FFF_FFFF);
        check_val("corner_max_neg1", out, 64'hFFFF_FFFF_8000_0001);
        run_stall_frame(32'sd123, -32'sd77);
        check_val("corner_min_max", out, 64'hC000_0000_8000_0000);
        run_frame(32'sd9, 32'sd9);
        check_val("stall_result", out, -64'sd9471);

        // Reset mid-frame while out holds a non-zero product.
        repeat (25) @(negedge clk);
        #2 reset = 1'b1;
        #1 check_val("reset_async", out, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        run_frame(32'sd6, 32'sd7);
        check_val("post_reset_b1", out, 64'd0);
        run_frame(32'sd1, 32'sd1);
        check_val("post_reset_b2", out, 64'sd42);

        for (int i = 0; i < 16; i++) begin
            if (i % 5 == 2) begin
                run_stall_frame($urandom, $urandom);
            end else begin
                run_frame($urandom, $urandom);
            end
        end
        run_frame(32'd0, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
